// File: rtl/traceback_emitter.sv
// rtl/traceback_emitter.sv - LIFO-buffered traceback replay emitting aligned columns in forward order.
// Optional running alignment score output is enabled by defining ALIGN_SCORE_EN.
module traceback_emitter #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int DEPTH       = 2 * LENGTH,
    parameter int SWIDTH      = 16,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int INDEL       = -1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LENGTH*CWIDTH-1:0]    s1,
    input  logic [LENGTH*CWIDTH-1:0]    s2,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*CORD_LENGTH-1:0]    in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CWIDTH-1:0]           out_c1,
    output logic [CWIDTH-1:0]           out_c2,
    output logic                        out_gap1,
    output logic                        out_gap2,
    output logic                        out_last,
    output logic                        busy,
    output logic                        error
`ifdef ALIGN_SCORE_EN
    ,
    output logic signed [SWIDTH-1:0]    score,
    output logic                        score_valid
`endif
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int SW = LENGTH * CWIDTH;
    localparam int DW = 2 * CORD_LENGTH;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                 state, state_next;
    logic [PW-1:0]          ptr;
    logic [DW-1:0]          mem [DEPTH];
    logic [CORD_LENGTH-1:0] px, py;
    logic                   first;
    logic                   err_r;
    logic [SW-1:0]          s1_r, s2_r;

    logic                   push, pop, overflow, last_err, col_err;
    logic [DW-1:0]          top;
    logic [CORD_LENGTH-1:0] tx, ty;
    logic [CWIDTH-1:0]      ch1, ch2;
    logic                   x_inc, x_same, y_inc, y_same, range_err;

    // Top-of-stack mux; loop compare avoids index-width coupling between ptr and DEPTH.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr == PW'(i + 1)) top = mem[i];
        end
    end

    assign tx = top[CORD_LENGTH-1:0];
    assign ty = top[DW-1:CORD_LENGTH];

    // Out-of-range coordinates fall through to character 0.
    always_comb begin
        ch1 = '0;
        ch2 = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (ty == CORD_LENGTH'(i)) ch1 = s1_r[i*CWIDTH +: CWIDTH];
            if (tx == CORD_LENGTH'(i)) ch2 = s2_r[i*CWIDTH +: CWIDTH];
        end
    end

    assign range_err = (tx >= CORD_LENGTH'(LENGTH)) || (ty >= CORD_LENGTH'(LENGTH));
    assign x_inc     = (tx == px + CORD_LENGTH'(1));
    assign x_same    = (tx == px);
    assign y_inc     = (ty == py + CORD_LENGTH'(1));
    assign y_same    = (ty == py);

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_c1     = '0;
        out_c2     = '0;
        out_gap1   = 1'b0;
        out_gap2   = 1'b0;
        out_last   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        overflow   = 1'b0;
        last_err   = 1'b0;
        col_err    = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (ptr == PW'(DEPTH)) overflow = 1'b1;
                    else                   push     = 1'b1;
                    if (in_last) state_next = DRAIN;
                end else if (in_last && ptr == '0) begin
                    last_err = 1'b1;
                end
            end
            DRAIN: begin
                if (ptr == '0) begin
                    state_next = FILL;
                end else begin
                    out_valid = 1'b1;
                    out_last  = (ptr == PW'(1));
                    if (first) begin
                        col_err = (tx != '0) || (ty != '0);
                        out_c1  = ch1;
                        out_c2  = ch2;
                    end else if (x_inc && y_inc) begin
                        out_c1 = ch1;
                        out_c2 = ch2;
                    end else if (x_inc && y_same) begin
                        out_gap1 = 1'b1;
                        out_c2   = ch2;
                    end else if (x_same && y_inc) begin
                        out_c1   = ch1;
                        out_gap2 = 1'b1;
                    end else begin
                        col_err = 1'b1;
                        out_c1  = ch1;
                        out_c2  = ch2;
                    end
                    if (range_err) col_err = 1'b1;
                    pop = out_ready;
                    if (out_ready && out_last) state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            px    <= '0;
            py    <= '0;
            first <= 1'b1;
            err_r <= 1'b0;
            s1_r  <= '0;
            s2_r  <= '0;
        end else begin
            if (push) begin
                ptr <= ptr + PW'(1);
                if (ptr == '0) begin
                    s1_r <= s1;
                    s2_r <= s2;
                end
            end
            if (pop) begin
                ptr   <= ptr - PW'(1);
                px    <= tx;
                py    <= ty;
                first <= (ptr == PW'(1));
            end
            if (overflow || last_err || (out_valid && col_err)) err_r <= 1'b1;
        end
    end

    // Storage needs no reset: the pointer alone defines valid contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && ptr == PW'(i)) mem[i] <= in_data;
        end
    end

    assign busy  = (state != FILL) || (ptr != '0);
    assign error = err_r;

`ifdef ALIGN_SCORE_EN
    logic signed [SWIDTH-1:0] acc, col_score;

    always_comb begin
        col_score = SWIDTH'(MISMATCH);
        if (out_gap1 || out_gap2) col_score = SWIDTH'(INDEL);
        else if (out_c1 == out_c2) col_score = SWIDTH'(MATCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            score       <= '0;
            score_valid <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (push && ptr == '0) acc <= '0;
            if (pop) begin
                acc <= acc + col_score;
                if (out_last) begin
                    score       <= acc + col_score;
                    score_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_traceback_emitter.sv
// tb/tb_traceback_emitter.sv - Directed table-driven bench for traceback_emitter (LENGTH=4, DEPTH=8).
module tb_traceback_emitter;
    localparam int L  = 4;
    localparam int CW = 2;
    localparam int CL = 8;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [L*CW-1:0] s1, s2;
    logic            in_valid, in_ready, in_last;
    logic [2*CL-1:0] in_data;
    logic            out_valid, out_ready;
    logic [CW-1:0]   out_c1, out_c2;
    logic            out_gap1, out_gap2, out_last, busy, error;
`ifdef ALIGN_SCORE_EN
    logic signed [15:0] score;
    logic               score_valid;
`endif

    always #5 clk = ~clk;

    traceback_emitter #(.LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .s1(s1), .s2(s2),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
        .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last),
        .busy(busy), .error(error)
`ifdef ALIGN_SCORE_EN
        , .score(score), .score_valid(score_valid)
`endif
    );

    typedef struct {
        int          job;
        logic [15:0] word;
        logic        last;
        logic [1:0]  c1, c2;
        logic        g1, g2, ol;
    } vec_t;

    vec_t tab[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cw(input int x, input int y);
        return {8'(y), 8'(x)};
    endfunction

    task automatic push(input logic [15:0] w, input logic l);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_valid_wait"}, 32'(out_valid), 32'd1);
    endtask

    task automatic chk_col(input string name, input int i);
        chk({name, "_c1"},   32'(out_c1),   32'(tab[i].c1));
        chk({name, "_c2"},   32'(out_c2),   32'(tab[i].c2));
        chk({name, "_gap1"}, 32'(out_gap1), 32'(tab[i].g1));
        chk({name, "_gap2"}, 32'(out_gap2), 32'(tab[i].g2));
        chk({name, "_last"}, 32'(out_last), 32'(tab[i].ol));
    endtask

    task automatic run_job(input int job, input bit stall, input int exp_score);
        int k = 0;
        for (int i = 0; i < 9; i++)
            if (tab[i].job == job) push(tab[i].word, tab[i].last);
        chk($sformatf("j%0d_first_valid_1cyc", job), 32'(out_valid), 32'd1);
        chk($sformatf("j%0d_in_ready_drain", job), 32'(in_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (tab[i].job != job) continue;
            wait_valid($sformatf("j%0d_col%0d", job, k));
            chk_col($sformatf("j%0d_s%0d_col%0d", job, stall, k), i);
            if (stall) begin
                out_ready = 1'b0;
                @(negedge clk);
                chk_col($sformatf("j%0d_held_col%0d", job, k), i);
                chk($sformatf("j%0d_held_valid%0d", job, k), 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            k++;
        end
        chk($sformatf("j%0d_done_valid", job), 32'(out_valid), 32'd0);
        chk($sformatf("j%0d_done_busy", job), 32'(busy), 32'd0);
        chk($sformatf("j%0d_done_in_ready", job), 32'(in_ready), 32'd1);
        chk($sformatf("j%0d_error", job), 32'(error), 32'd0);
`ifdef ALIGN_SCORE_EN
        chk($sformatf("j%0d_score_valid", job), 32'(score_valid), 32'd1);
        chk($sformatf("j%0d_score", job), 32'(score), 32'(exp_score));
`else
        if (exp_score == 0) $display("note: zero expected score");
`endif
    endtask

    initial begin
        int cnt;
        int t;
        tab[0] = '{0, cw(3,3), 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{0, cw(2,2), 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
        tab[2] = '{0, cw(1,1), 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
        tab[3] = '{0, cw(0,0), 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1};
        tab[4] = '{1, cw(3,3), 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        tab[5] = '{1, cw(2,2), 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0};
        tab[6] = '{1, cw(1,2), 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0};
        tab[7] = '{1, cw(0,1), 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0};
        tab[8] = '{1, cw(0,0), 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1};

        s1 = {2'd3, 2'd2, 2'd1, 2'd0};
        s2 = {2'd3, 2'd2, 2'd1, 2'd0};
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        do_reset();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c", 32'({out_c1, out_c2}), 32'd0);
        chk("rst_gaps", 32'({out_gap1, out_gap2}), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        run_job(0, 1'b0, 4);
        run_job(1, 1'b0, -1);
        run_job(1, 1'b1, -1);

        // in_last without a word on an empty LIFO
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        chk("lastempty_error", 32'(error), 32'd1);
        chk("lastempty_fill", 32'(in_ready), 32'd1);
        chk("lastempty_busy", 32'(busy), 32'd0);
        do_reset();
        chk("reset_clears_error", 32'(error), 32'd0);

        // overflow: 8 fit, 9th dropped
        for (int i = 0; i < 8; i++) push(cw(7 - i, 7 - i), 1'b0);
        chk("ovf_8_no_error", 32'(error), 32'd0);
        push(cw(9, 9), 1'b0);
        chk("ovf_9_error", 32'(error), 32'd1);
        push(cw(9, 9), 1'b1);
        cnt = 0; t = 0;
        out_ready = 1'b1;
        while (t < 30) begin
            if (out_valid) begin
                cnt++;
                if (out_last) begin
                    @(negedge clk);
                    break;
                end
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        chk("ovf_lifo_entries", 32'(cnt), 32'd8);
        chk("ovf_error_sticky", 32'(error), 32'd1);
        do_reset();

        // first popped entry not (0,0)
        push(cw(1, 0), 1'b1);
        chk("bad_first_c1", 32'(out_c1), 32'd0);
        chk("bad_first_c2", 32'(out_c2), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bad_first_error", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        chk("bad_first_sticky", 32'(error), 32'd1);
        do_reset();

        // delta (2,0)
        push(cw(2, 0), 1'b0);
        push(cw(0, 0), 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("delta_first_ok", 32'(error), 32'd0);
        chk("delta_second_gap1", 32'(out_gap1), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("delta_error", 32'(error), 32'd1);
        do_reset();

        // reset during drain after two columns
        for (int i = 0; i < 4; i++) push(tab[i].word, tab[i].last);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("middrain_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("middrain_rst_valid", 32'(out_valid), 32'd0);
        chk("middrain_rst_in_ready", 32'(in_ready), 32'd1);
        chk("middrain_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        push(cw(0, 0), 1'b1);
        s1 = '1;
        s2 = '1;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_c", 32'({out_c1, out_c2}), 32'd0);
        chk("one_last", 32'(out_last), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("one_done_valid", 32'(out_valid), 32'd0);
        chk("one_error", 32'(error), 32'd0);
`ifdef ALIGN_SCORE_EN
        chk("one_score", 32'(score), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
